digit_frame_mux: RTL and testbench

// - Downstream of the 8-digit anode scanner: consumes its 3-bit seg_sel and drives the shared cathodes.
// - Holds a 32-bit display word (8 hex nibbles), selects the nibble for the active digit and decodes it to 7 segments.
// - New words are double-buffered and committed only at a frame boundary (seg_sel 7->0), so a frame never shows mixed data.
// - Adds per-digit decimal point and per-digit frame-synchronous blink.

---
 rtl/digit_frame_mux.sv | 119 +++++++++++
 tb/tb_digit_frame_mux.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/digit_frame_mux.sv
// Cathode driver for an 8-digit multiplexed hex display: double-buffered display word
// committed on the 7->0 frame boundary, hex decode, per-digit decimal point and blink.
module digit_frame_mux #(
  parameter int BLINK_FRAMES = 30
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  seg_sel,
  input  logic [31:0] data_in,
  input  logic        load,
  output logic        load_ack,
  output logic        pending,
  input  logic [7:0]  dp_in,
  input  logic [7:0]  blink_en,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int CW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BLINK_FRAMES - 1);

  logic [2:0]    r_sel_q;
  logic [31:0]   r_display;
  logic [31:0]   r_pend;
  logic          r_pending;
  logic          r_load_ack;
  logic [CW-1:0] r_blink_cnt;
  logic          r_blink_phase;
  logic [6:0]    r_seg;
  logic          r_dp;

  logic          w_wrap;
  logic [3:0]    w_nib;
  logic [6:0]    w_hex;
  logic          w_blank;

  assign w_wrap  = (r_sel_q == 3'd7) && (seg_sel == 3'd0);
  assign w_nib   = r_display[{seg_sel, 2'b00} +: 4];
  assign w_blank = r_blink_phase && blink_en[seg_sel];

  always_comb begin
    w_hex = 7'b1111111;
    case (w_nib)
      4'h0: w_hex = 7'b0000001;
      4'h1: w_hex = 7'b1001111;
      4'h2: w_hex = 7'b0010010;
      4'h3: w_hex = 7'b0000110;
      4'h4: w_hex = 7'b1001100;
      4'h5: w_hex = 7'b0100100;
      4'h6: w_hex = 7'b0100000;
      4'h7: w_hex = 7'b0001111;
      4'h8: w_hex = 7'b0000000;
      4'h9: w_hex = 7'b0000100;
      4'hA: w_hex = 7'b0001000;
      4'hB: w_hex = 7'b1100000;
      4'hC: w_hex = 7'b0110001;
      4'hD: w_hex = 7'b1000010;
      4'hE: w_hex = 7'b0110000;
      4'hF: w_hex = 7'b0111000;
      default: w_hex = 7'b1111111;
    endcase
  end

  // Commit happens before the same-cycle load, so the older pending word is never lost.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sel_q    <= 3'd0;
      r_display  <= 32'd0;
      r_pend     <= 32'd0;
      r_pending  <= 1'b0;
      r_load_ack <= 1'b0;
    end else begin
      r_sel_q    <= seg_sel;
      r_load_ack <= load;
      if (w_wrap && r_pending) begin
        r_display <= r_pend;
      end
      if (load) begin
        r_pend    <= data_in;
        r_pending <= 1'b1;
      end else if (w_wrap) begin
        r_pending <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else if (w_wrap) begin
      if (r_blink_cnt == CNT_LAST) begin
        r_blink_cnt   <= '0;
        r_blink_phase <= ~r_blink_phase;
      end else begin
        r_blink_cnt <= r_blink_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_seg <= 7'b1111111;
      r_dp  <= 1'b1;
    end else if (w_blank) begin
      r_seg <= 7'b1111111;
      r_dp  <= 1'b1;
    end else begin
      r_seg <= w_hex;
      r_dp  <= ~dp_in[seg_sel];
    end
  end

  assign load_ack = r_load_ack;
  assign pending  = r_pending;
  assign seg      = r_seg;
  assign dp       = r_dp;

endmodule

// File: tb/tb_digit_frame_mux.sv
// Bench for digit_frame_mux: directed frame scenarios plus randomized scanning, all
// checked every cycle against a word/frame-level reference model.
module tb_digit_frame_mux;

  localparam int BF = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [2:0]  seg_sel = 3'd0;
  logic [31:0] data_in = 32'd0;
  logic        load = 1'b0;
  logic        load_ack;
  logic        pending;
  logic [7:0]  dp_in = 8'd0;
  logic [7:0]  blink_en = 8'd0;
  logic [6:0]  seg;
  logic        dp;

  int n_chk = 0;
  int n_err = 0;

  // Reference model state: shown word, waiting word, frames seen since reset.
  logic [31:0] m_disp, m_pend;
  logic        m_pending, m_ack, m_dp;
  logic [2:0]  m_prev_sel;
  logic [6:0]  m_seg;
  int          m_frames;

  digit_frame_mux #(.BLINK_FRAMES(BF)) dut (
    .clk(clk), .reset(reset), .seg_sel(seg_sel), .data_in(data_in),
    .load(load), .load_ack(load_ack), .pending(pending),
    .dp_in(dp_in), .blink_en(blink_en), .seg(seg), .dp(dp)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] t [16];
    t = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
          7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
          7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
          7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
    return t[n];
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_disp = 32'd0; m_pend = 32'd0; m_pending = 1'b0; m_ack = 1'b0;
    m_prev_sel = 3'd0; m_frames = 0; m_seg = 7'h7F; m_dp = 1'b1;
  endtask

  task automatic model_edge();
    int phase;
    if (!reset) begin
      model_reset();
      return;
    end
    phase = (m_frames / BF) % 2;
    if (phase == 1 && blink_en[seg_sel]) begin
      m_seg = 7'h7F; m_dp = 1'b1;
    end else begin
      m_seg = hex7(4'((m_disp >> (4 * int'(seg_sel))) & 32'hF));
      m_dp  = ~dp_in[seg_sel];
    end
    m_ack = load;
    if (m_prev_sel == 3'd7 && seg_sel == 3'd0) begin
      m_frames++;
      if (m_pending) begin
        m_disp = m_pend;
        m_pending = 1'b0;
      end
    end
    if (load) begin
      m_pend = data_in;
      m_pending = 1'b1;
    end
    m_prev_sel = seg_sel;
  endtask

  task automatic compare();
    check("seg", 32'(seg), 32'(m_seg));
    check("dp", 32'(dp), 32'(m_dp));
    check("pending", 32'(pending), 32'(m_pending));
    check("load_ack", 32'(load_ack), 32'(m_ack));
  endtask

  task automatic tick();
    @(posedge clk);
    if (load && reset) $display("load data_in=%08h at seg_sel=%0d", data_in, seg_sel);
    model_edge();
    #1;
    compare();
  endtask

  task automatic hold_sel(input logic [2:0] s, input int cycles);
    seg_sel = s;
    repeat (cycles) tick();
  endtask

  task automatic pulse_load(input logic [31:0] d);
    data_in = d; load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  task automatic run_frame_to(input logic [2:0] from, input logic [2:0] upto);
    for (int s = int'(from); s <= int'(upto); s++) hold_sel(3'(s), 3);
  endtask

  initial begin
    model_reset();
    // Reset held low, then released with digit 0 selected.
    seg_sel = 3'd0;
    repeat (3) tick();
    check("reset_seg", 32'(seg), 32'h7F);
    reset = 1'b1;
    tick();
    check("post_reset_digit0", 32'(seg), 32'(7'b0000001));
    check("post_reset_dp", 32'(dp), 32'd1);
    check("post_reset_pending", 32'(pending), 32'd0);

    // Single load mid-frame, committed at the 7->0 boundary.
    hold_sel(3'd2, 3);
    hold_sel(3'd3, 2);
    pulse_load(32'h12345678);
    check("load_ack_pulse", 32'(load_ack), 32'd1);
    tick();
    check("load_ack_once", 32'(load_ack), 32'd0);
    check("pending_set", 32'(pending), 32'd1);
    hold_sel(3'd4, 3);
    check("old_digit4", 32'(seg), 32'(7'b0000001));
    run_frame_to(3'd5, 3'd7);
    check("old_digit7", 32'(seg), 32'(7'b0000001));
    hold_sel(3'd0, 3);
    check("pending_clear", 32'(pending), 32'd0);
    check("new_digit0", 32'(seg), 32'(7'b0000000));
    hold_sel(3'd3, 3);
    check("new_digit3", 32'(seg), 32'(7'b0100100));

    // Two loads in one frame: last word wins.
    hold_sel(3'd1, 2);
    pulse_load(32'hAAAAAAAA);
    hold_sel(3'd2, 2);
    pulse_load(32'h0000000F);
    run_frame_to(3'd3, 3'd7);
    hold_sel(3'd0, 3);
    check("last_wins_d0", 32'(seg), 32'(7'b0111000));
    hold_sel(3'd1, 3);
    check("last_wins_d1", 32'(seg), 32'(7'b0000001));

    // Load in the exact wrap cycle while another word is pending.
    hold_sel(3'd4, 2);
    pulse_load(32'h00000002);
    run_frame_to(3'd5, 3'd7);
    seg_sel = 3'd0;
    pulse_load(32'h00000001);
    hold_sel(3'd0, 2);
    check("wrap_load_d0", 32'(seg), 32'(7'b0010010));
    check("wrap_load_pending", 32'(pending), 32'd1);
    run_frame_to(3'd1, 3'd7);
    hold_sel(3'd0, 3);
    check("wrap_load_next", 32'(seg), 32'(7'b1001111));

    // Blink on digit 0 with its decimal point enabled.
    blink_en = 8'h01; dp_in = 8'h01;
    for (int f = 0; f < 8; f++) begin
      run_frame_to(3'd1, 3'd7);
      hold_sel(3'd0, 3);
    end

    // Reset during a pending load discards the word.
    blink_en = 8'h00; dp_in = 8'h00;
    hold_sel(3'd2, 2);
    pulse_load(32'hFFFFFFFF);
    hold_sel(3'd5, 2);
    reset = 1'b0;
    model_reset();
    #1;
    compare();
    check("async_reset_pending", 32'(pending), 32'd0);
    tick();
    reset = 1'b1;
    run_frame_to(3'd5, 3'd7);
    hold_sel(3'd0, 3);
    check("reset_discard_d0", 32'(seg), 32'(7'b0000001));

    // Randomized scanning, loads, jumps, live dp/blink and occasional reset.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(19) == 0) seg_sel = 3'($urandom_range(7));
      else if ($urandom_range(2) == 0) seg_sel = seg_sel + 3'd1;
      if ($urandom_range(7) == 0) begin
        data_in = $urandom;
        load = 1'b1;
      end else begin
        load = 1'b0;
      end
      if ($urandom_range(31) == 0) blink_en = 8'($urandom);
      if ($urandom_range(31) == 0) dp_in = 8'($urandom);
      if ($urandom_range(499) == 0) begin
        reset = 1'b0;
        model_reset();
        #1;
        compare();
      end else begin
        reset = 1'b1;
      end
      tick();
    end
    load = 1'b0;
    reset = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
